uart_tx_line_receiver: RTL
==========================

Name: uart_tx_line_receiver

Overview:
- Serial-side consumer of the UART transmit line (uart_tx_o of udma_uart_top).
- Oversamples the line in the peripheral clock domain and deframes characters using the same divisor/format settings the DUT is programmed with.
- Pushes received characters into a small FIFO with a valid/ready output and flags parity, framing and overflow errors.
- Used as the receive half of the UART VIP and as a loopback checker.

Parameters:
- FIFO_DEPTH, 4, receive buffer entries; must be a power of 2, at least 2.
- DIV_WIDTH, 16, width of the clock divisor input.

Ports:
- periph_clk_i  in  1  sampling clock.
- rst_i  in  1  synchronous, active-high reset.
- uart_line_i  in  1  serial line, connected to uart_tx_o; idle high; asynchronous to periph_clk_i.
- cfg_en_i  in  1  receiver enable.
- cfg_div_i  in  DIV_WIDTH  bit period minus 1, in periph_clk_i cycles; legal when at least 3.
- cfg_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- cfg_parity_en_i  in  1  even parity bit present after the data bits.
- cfg_stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits.
- data_o  out  8  received character, LSB first on the line, zero-extended above cfg_bits.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o.
- parity_err_o  out  1  one-cycle pulse on a parity mismatch.
- frame_err_o  out  1  one-cycle pulse when a stop bit samples low.
- overflow_o  out  1  one-cycle pulse when a character is dropped because the FIFO is full.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0, data_o=0. The synchroniser resets to 1.
- Input synchronisation:
  - uart_line_i passes through a 2-flop synchroniser giving line_s.
  - A falling edge is detected on line_s against its previous value.
- State machine, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: when cfg_en_i=1 and a falling edge is seen, load cnt=cfg_div_i>>1 and go to START.
  - START: cnt counts down to 0. At 0, if line_s=1 (false start) go to IDLE with no error. Otherwise load cnt=cfg_div_i, set bit_idx=0 and go to DATA.
  - DATA: at cnt=0, shift line_s into shreg[bit_idx] and reload cnt. After bit_idx = ndata-1, go to PARITY if cfg_parity_en_i=1, else STOP.
  - PARITY: at cnt=0, compare line_s with the XOR of the data bits. A mismatch latches perr. Then go to STOP.
  - STOP: at cnt=0, a line_s=0 sample latches ferr.
    - With cfg_stop_bits_i=1, a second stop period is sampled the same way.
    - On the final stop sample, commit the character and go to IDLE.
- Sample timing: every sample is taken at the bit centre, (cfg_div_i+1)*k + cfg_div_i/2 cycles after the synchronised falling edge.
- Commit cycle:
  - The character is written into the FIFO if it is not full; otherwise it is dropped and overflow_o pulses.
  - parity_err_o and frame_err_o pulse in the same cycle as the commit, whether or not the character was stored.
  - Characters with errors are still stored.
  - Latency: valid_o rises 1 cycle after commit when the FIFO was empty.
- FIFO:
  - Pop when valid_o && ready_i.
  - A push and a pop in the same cycle on a full FIFO succeed with no overflow; the pop frees the slot.
  - data_o shows the head entry; it is 0 when empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- cfg_en_i deasserted mid-frame: the frame is abandoned and the state returns to IDLE next cycle. Nothing is committed and FIFO contents are kept.
- Configuration inputs must be stable while busy_o=1; behaviour is undefined otherwise.
- rst_i mid-frame: on the next edge the state returns to IDLE and the FIFO flushes.
- A break (line held low) produces the character 0x00 with frame_err_o. No new start is detected until line_s has been seen high.

Decomposition:
- uart_vip_pkg holds:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP);
  - bits-encoding constants BITS_5..BITS_8;
  - function nbits(cfg_bits) returning 5..8.
- Sub-module uart_rx_fifo is a parameterised synchronous FIFO with push/pop/full/empty. Reused by the TX VIP side.

Test Plan:
- cfg_div=15, 8 bits, no parity, 1 stop; drive 0x55 on the line -> data_o=0x55, valid_o high (16*10-8)+3 cycles after the start edge (±1), no error pulses.
- 7 bits, parity_en=1; send 0x23 with wrong parity bit 0 -> data_o=0x23, parity_err_o pulses once, frame_err_o=0.
- 1-cycle-wide low glitch (cfg_div=15) -> no commit, busy_o returns low within 9 cycles.
- FIFO_DEPTH=4, ready_i=0; send 5 characters 0x01..0x05 -> overflow_o pulses once on the 5th; pops return 0x01..0x04.
- Stop bit forced low, 2-stop mode, character 0xA5 -> frame_err_o pulses, 0xA5 is stored; line held low -> 0x00 with frame_err_o, no further characters until the line is high.
- rst_i asserted mid-DATA, or cfg_en_i dropped -> busy_o=0 next cycle; valid_o=0 after reset, FIFO retained after the enable drop.

Source files
------------

// File: rtl/uart_vip_pkg.sv
// Shared definitions for the UART VIP receive and transmit halves.
//   rx_state_e     : receiver state encoding (IDLE, START, DATA, PARITY, STOP)
//   ST_*           : plain logic constants of the same encoding for the FSM register
//   BITS_5..BITS_8 : cfg_bits encodings for 5..8 data bits
//   nbits()        : number of data bits selected by a cfg_bits value
package uart_vip_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    function automatic logic [3:0] nbits(input logic [1:0] cfg_bits);
        case (cfg_bits)
            BITS_5:  return 4'd5;
            BITS_6:  return 4'd6;
            BITS_7:  return 4'd7;
            BITS_8:  return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with push/pop and full/empty flags.
//   clk_i, rst_i : clock, synchronous active-high reset (flushes pointers)
//   push_i       : write wdata_i; accepted when not full, or when a pop
//                  happens in the same cycle (the pop frees the slot)
//   pop_i        : drop the head entry; ignored when empty
//   rdata_o      : head entry, forced to 0 when empty
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module uart_rx_fifo
    import uart_vip_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_acc;
    logic             pop_acc;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_acc  = pop_i & ~empty_o;
    assign push_acc = push_i & (~full_o | pop_acc);
    assign rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_acc) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_line_receiver.sv
// Receive half of the UART VIP: oversamples the DUT's uart_tx_o line,
// deframes characters and queues them in a small FIFO.
//   periph_clk_i, rst_i : sampling clock, synchronous active-high reset
//   uart_line_i         : asynchronous serial line, idle high
//   cfg_*               : enable, bit period minus 1, data bits, parity, stop bits
//   data_o/valid_o/ready_i : received character stream (valid/ready)
//   parity_err_o, frame_err_o, overflow_o : one-cycle pulses in the commit cycle
//   busy_o              : receiver is inside a frame
//   dbg_state_o         : FSM state (rx_state_e encoding)
//
// Handshake: a character leaves the FIFO on every rising clock edge where
// valid_o and ready_i are both high; data_o is stable while valid_o is high
// and ready_i is low.
module uart_tx_line_receiver
    import uart_vip_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 periph_clk_i,
    input  logic                 rst_i,
    input  logic                 uart_line_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic [1:0]           cfg_bits_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_stop_bits_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overflow_o,
    output logic                 busy_o,
    output logic [2:0]           dbg_state_o
);

    logic                 sync1_q, sync1_d;
    logic                 line_s_q, line_s_d;
    logic                 line_prev_q, line_prev_d;
    logic [2:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 stop_idx_q, stop_idx_d;

    logic       fall;
    logic       cnt_zero;
    logic [3:0] ndata;
    logic       commit;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    assign sync1_d     = uart_line_i;
    assign line_s_d    = sync1_q;
    assign line_prev_d = line_s_q;

    // Edge detection (not level) means a held-low break cannot retrigger
    // until the line has been seen high again.
    assign fall     = line_prev_q & ~line_s_q;
    assign cnt_zero = (cnt_q == '0);
    assign ndata    = nbits(cfg_bits_i);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop_idx_d = stop_idx_q;
        commit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i && fall) begin
                    cnt_d   = cfg_div_i >> 1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end else if (line_s_q) begin
                    state_d = ST_IDLE;      // glitch, not a start bit
                end else begin
                    cnt_d      = cfg_div_i;
                    bit_idx_d  = '0;
                    shreg_d    = '0;        // keeps unused upper bits zero
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop_idx_d = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end else begin
                    shreg_d[bit_idx_q] = line_s_q;
                    cnt_d              = cfg_div_i;
                    if ({1'b0, bit_idx_q} == ndata - 4'd1) begin
                        state_d = cfg_parity_en_i ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end else begin
                    perr_d  = (line_s_q != ^shreg_q);
                    cnt_d   = cfg_div_i;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end else if (cfg_stop_bits_i && !stop_idx_q) begin
                    ferr_d     = ferr_q | ~line_s_q;
                    stop_idx_d = 1'b1;
                    cnt_d      = cfg_div_i;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping the enable abandons the frame without committing anything.
        if (!cfg_en_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge periph_clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            line_s_q    <= 1'b1;
            line_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            stop_idx_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            line_s_q    <= line_s_d;
            line_prev_q <= line_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            stop_idx_q  <= stop_idx_d;
        end
    end

    assign pop     = valid_o & ready_i;
    assign valid_o = ~fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (periph_clk_i),
        .rst_i   (rst_i),
        .push_i  (commit),
        .wdata_i (shreg_q),
        .pop_i   (pop),
        .rdata_o (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The final stop sample is still on the line in the commit cycle.
    assign parity_err_o = commit & perr_q;
    assign frame_err_o  = commit & (ferr_q | ~line_s_q);
    assign overflow_o   = commit & fifo_full & ~pop;
    assign busy_o       = (state_q != ST_IDLE);
    assign dbg_state_o  = state_q;

endmodule
